// File: rtl/framebuffer_scan_reader.sv
// framebuffer_scan_reader
//
// Read side of the cell frame buffer. It walks the cell RAM in raster order and
// produces VGA timing plus 12-bit RGB. Each cell code goes through a fixed
// palette. A crosshair cursor is drawn over the image at the mouse position.
//
// Ports
//   clk_i               pixel clock
//   reset_ni            asynchronous active-low reset
//   mouse_x_position_i  cursor column
//   mouse_y_position_i  cursor row
//   ram_rd_address_o    row-major cell read address (registered)
//   ram_rd_data_i       cell code, valid RAM_LATENCY clocks after its address
//   rgb_o               {R,G,B} 4 bits each, 0 during blanking
//   hsync_o, vsync_o    active-low sync pulses
//   video_active_o      high while rgb_o carries a visible pixel
//   frame_start_o       one-clock pulse aligned with pixel (0,0) on rgb_o
//
// Timing: the h/v counters and the read address describe pixel N. Every output
// describes pixel N-P, where P = RAM_LATENCY+1. There is no handshake. RAM data
// is assumed valid exactly RAM_LATENCY clocks after the address is presented.
module framebuffer_scan_reader #(
    parameter int          COLUMNS      = 640,
    parameter int          ROWS         = 480,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          RAM_LATENCY  = 1,
    parameter int          CELL_WIDTH   = 2,
    parameter logic [11:0] CURSOR_COLOR = 12'hF00
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [$clog2(COLUMNS)-1:0]        mouse_x_position_i,
    input  logic [$clog2(ROWS)-1:0]           mouse_y_position_i,
    output logic [$clog2(COLUMNS*ROWS)-1:0]   ram_rd_address_o,
    input  logic [CELL_WIDTH-1:0]             ram_rd_data_i,
    output logic [11:0]                       rgb_o,
    output logic                              hsync_o,
    output logic                              vsync_o,
    output logic                              video_active_o,
    output logic                              frame_start_o
);

    localparam int H_TOTAL = COLUMNS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = ROWS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(COLUMNS*ROWS);
    localparam int P       = RAM_LATENCY + 1;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(COLUMNS);
    localparam logic [HW-1:0] H_SYNC_START = HW'(COLUMNS + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(COLUMNS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(ROWS);
    localparam logic [VW-1:0] V_SYNC_START = VW'(ROWS + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(ROWS + V_FP + V_SYNC);
    localparam logic [HW:0]   H_REACH      = (HW+1)'(2);
    localparam logic [VW:0]   V_REACH      = (VW+1)'(2);

    logic [HW-1:0] h_q, h_next;
    logic [VW-1:0] v_q, v_next;
    logic [AW-1:0] addr_q, addr_next;
    logic          next_active, next_origin;

    // Counter next-state. The address steps only when moving onto an active
    // pixel, so it holds the last address of the line through blanking.
    // When the scan wraps to (0,0) the address is reset to 0.
    always_comb begin
        h_next = h_q + 1'b1;
        v_next = v_q;
        if (h_q == H_LAST) begin
            h_next = '0;
            v_next = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        next_active = (h_next < H_ACT) && (v_next < V_ACT);
        next_origin = (h_next == '0) && (v_next == '0);
        addr_next   = addr_q;
        if (next_origin) begin
            addr_next = '0;
        end else if (next_active) begin
            addr_next = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
        end else begin
            h_q    <= h_next;
            v_q    <= v_next;
            addr_q <= addr_next;
        end
    end

    // Decode of the pixel the counters currently point at.
    logic cur_active, cur_hsync, cur_vsync, cur_frame_start, cur_hit;
    logic [HW:0] h_ext, mx_ext;
    logic [VW:0] v_ext, my_ext;
    logic        on_col, on_row, near_h, near_v;

    always_comb begin
        cur_active      = (h_q < H_ACT) && (v_q < V_ACT);
        cur_hsync       = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
        cur_vsync       = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
        cur_frame_start = (h_q == '0) && (v_q == '0);
        // One extra bit keeps the +/-2 window from wrapping, so a cursor at the
        // left/top edge draws nothing at the far edge.
        h_ext  = {1'b0, h_q};
        v_ext  = {1'b0, v_q};
        mx_ext = (HW+1)'(mouse_x_position_i);
        my_ext = (VW+1)'(mouse_y_position_i);
        on_col = (h_ext == mx_ext);
        on_row = (v_ext == my_ext);
        near_h = (h_ext + H_REACH >= mx_ext) && (h_ext <= mx_ext + H_REACH);
        near_v = (v_ext + V_REACH >= my_ext) && (v_ext <= my_ext + V_REACH);
        cur_hit = (on_col && near_v) || (on_row && near_h);
    end

    // Delay lines. Sync/active/frame-start use all P stages. The active and
    // hit taps at stage P-2 line up with read data arriving from the RAM.
    logic [P-1:0] act_pipe, hs_pipe, vs_pipe, fs_pipe;
    logic [P-2:0] hit_pipe;
    logic [11:0]  rgb_q;
    logic [11:0]  pal_color;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            act_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            fs_pipe  <= '0;
            hit_pipe <= '0;
        end else begin
            act_pipe[0] <= cur_active;
            hs_pipe[0]  <= cur_hsync;
            vs_pipe[0]  <= cur_vsync;
            fs_pipe[0]  <= cur_frame_start;
            hit_pipe[0] <= cur_hit;
            for (int i = 1; i < P; i++) begin
                act_pipe[i] <= act_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                fs_pipe[i]  <= fs_pipe[i-1];
            end
            for (int i = 1; i < P-1; i++) begin
                hit_pipe[i] <= hit_pipe[i-1];
            end
        end
    end

    always_comb begin
        pal_color = 12'hF0F;
        case (ram_rd_data_i)
            CELL_WIDTH'(0): pal_color = 12'h000;
            CELL_WIDTH'(1): pal_color = 12'hDB5;
            CELL_WIDTH'(2): pal_color = 12'h888;
            CELL_WIDTH'(3): pal_color = 12'h04F;
            default:        pal_color = 12'hF0F;
        endcase
    end

    // Blanking beats cursor, and the cursor beats the palette colour.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rgb_q <= '0;
        end else if (!act_pipe[P-2]) begin
            rgb_q <= '0;
        end else if (hit_pipe[P-2]) begin
            rgb_q <= CURSOR_COLOR;
        end else begin
            rgb_q <= pal_color;
        end
    end

    assign ram_rd_address_o = addr_q;
    assign rgb_o            = rgb_q;
    assign hsync_o          = hs_pipe[P-1];
    assign vsync_o          = vs_pipe[P-1];
    assign video_active_o   = act_pipe[P-1];
    assign frame_start_o    = fs_pipe[P-1];

endmodule

// File: tb/tb_framebuffer_scan_reader.sv
// Bench for framebuffer_scan_reader at a reduced raster (16x12 active,
// 24x16 total, 384 clocks per frame). Two instances with RAM_LATENCY 1 and 3
// share the stimulus. Each has its own synchronous RAM model.
module tb_framebuffer_scan_reader;
    localparam int COLS = 16, ROWS = 12;
    localparam int HFP = 2, HSY = 4, HBP = 2;
    localparam int VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = COLS + HFP + HSY + HBP;   // 24
    localparam int VT = ROWS + VFP + VSY + VBP;   // 16
    localparam int FRAME = HT * VT;               // 384
    localparam int P1 = 2, P3 = 4;
    localparam logic [15:0] RST_OUT = 16'h6000;   // {fs=0,vs=1,hs=1,act=0,rgb=0}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [3:0]  mx, my;
    logic [7:0]  addr1, addr3;
    logic [1:0]  rd1, rd3a, rd3b, rd3c;
    logic [11:0] rgb1, rgb3;
    logic        hs1, vs1, act1, fs1, hs3, vs3, act3, fs3;
    logic [1:0]  mem [COLS*ROWS];

    always @(posedge clk) begin
        rd1  <= mem[addr1];
        rd3a <= mem[addr3];
        rd3b <= rd3a;
        rd3c <= rd3b;
    end

    framebuffer_scan_reader #(
        .COLUMNS(COLS), .ROWS(ROWS), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .RAM_LATENCY(1), .CELL_WIDTH(2),
        .CURSOR_COLOR(12'hF00)
    ) dut1 (
        .clk_i(clk), .reset_ni(reset_n),
        .mouse_x_position_i(mx), .mouse_y_position_i(my),
        .ram_rd_address_o(addr1), .ram_rd_data_i(rd1),
        .rgb_o(rgb1), .hsync_o(hs1), .vsync_o(vs1),
        .video_active_o(act1), .frame_start_o(fs1)
    );

    framebuffer_scan_reader #(
        .COLUMNS(COLS), .ROWS(ROWS), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .RAM_LATENCY(3), .CELL_WIDTH(2),
        .CURSOR_COLOR(12'hF00)
    ) dut3 (
        .clk_i(clk), .reset_ni(reset_n),
        .mouse_x_position_i(mx), .mouse_y_position_i(my),
        .ram_rd_address_o(addr3), .ram_rd_data_i(rd3c),
        .rgb_o(rgb3), .hsync_o(hs3), .vsync_o(vs3),
        .video_active_o(act3), .frame_start_o(fs3)
    );

    // ---------------- reference model ----------------
    function automatic logic [11:0] pal(input logic [1:0] c);
        case (c)
            2'd0:    return 12'h000;
            2'd1:    return 12'hDB5;
            2'd2:    return 12'h888;
            default: return 12'h04F;
        endcase
    endfunction

    // Expected {fs,vs,hs,act,rgb} for the k-th pixel position after release.
    function automatic logic [15:0] model(input int k);
        int kk, h, v, dx, dy;
        logic act, hs, vs, fs, hit;
        logic [11:0] rgb;
        kk  = k % FRAME;
        h   = kk % HT;
        v   = kk / HT;
        act = (h < COLS) && (v < ROWS);
        hs  = !((h >= COLS + HFP) && (h < COLS + HFP + HSY));
        vs  = !((v >= ROWS + VFP) && (v < ROWS + VFP + VSY));
        fs  = (kk == 0);
        dx  = h - int'(mx);
        dy  = v - int'(my);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        hit = (dx == 0 && dy <= 2) || (dy == 0 && dx <= 2);
        rgb = !act ? 12'h000 : (hit ? 12'hF00 : pal(mem[v*COLS + h]));
        return {fs, vs, hs, act, rgb};
    endfunction

    function automatic logic [15:0] addr_model(input int k);
        int kk, h, v;
        kk = k % FRAME;
        h  = kk % HT;
        v  = kk / HT;
        if (v >= ROWS)     return 16'(COLS*ROWS - 1);
        else if (h < COLS) return 16'(v*COLS + h);
        else               return 16'(v*COLS + COLS - 1);
    endfunction

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int n = 0;
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q3[$];
    int mm_cnt = 0, first_id = 0, first_n = 0;
    logic [15:0] first_got, first_exp;
    int c_red, c_act, c_hs, c_vs, c_fs, c_col;
    logic [11:0] cur_color;

    task automatic note(input int id, input logic [15:0] got, input logic [15:0] exp);
        if (got !== exp) begin
            if (mm_cnt == 0) begin
                first_id  = id;
                first_n   = n;
                first_got = got;
                first_exp = exp;
            end
            mm_cnt++;
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] got1, got3, e1, e3;
        got1 = {fs1, vs1, hs1, act1, rgb1};
        got3 = {fs3, vs3, hs3, act3, rgb3};
        if (!reset_n) begin
            n = 0;
            note(0, got1, RST_OUT);
            note(1, got3, RST_OUT);
            note(4, {8'h00, addr1}, 16'h0000);
            note(5, {8'h00, addr3}, 16'h0000);
            exp_q1.delete();
            exp_q3.delete();
            for (int i = 0; i < P1 - 1; i++) exp_q1.push_back(RST_OUT);
            for (int i = 0; i < P3 - 1; i++) exp_q3.push_back(RST_OUT);
            exp_q1.push_back(model(0));
            exp_q3.push_back(model(0));
        end else begin
            n++;
            exp_q1.push_back(model(n));
            exp_q3.push_back(model(n));
            e1 = exp_q1.pop_front();
            e3 = exp_q3.pop_front();
            note(2, got1, e1);
            note(3, got3, e3);
            note(4, {8'h00, addr1}, addr_model(n));
            note(5, {8'h00, addr3}, addr_model(n));
            if (n >= P1 && n < P1 + FRAME) begin
                if (rgb1 == 12'hF00)   c_red++;
                if (rgb1 == cur_color) c_col++;
                if (act1)  c_act++;
                if (!hs1)  c_hs++;
                if (!vs1)  c_vs++;
                if (fs1)   c_fs++;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic check_stream(input string name);
        checks++;
        if (mm_cnt != 0) begin
            errors++;
            $display("FAIL %s stream: %0d bad samples, first at cycle %0d probe %0d got %h want %h",
                     name, mm_cnt, first_n, first_id, first_got, first_exp);
        end
        mm_cnt = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input int mode);
        for (int a = 0; a < COLS*ROWS; a++) begin
            case (mode)
                0:       mem[a] = 2'd0;
                1:       mem[a] = 2'd2;
                default: mem[a] = 2'(a % 4);
            endcase
        end
    endtask

    // Reset for two clocks with the new scene loaded, then release at neg+1.
    task automatic start_scene(input int x, input int y, input int mode, input logic [11:0] col);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        mx = 4'(x);
        my = 4'(y);
        fill_mem(mode);
        cur_color = col;
        c_red = 0; c_act = 0; c_hs = 0; c_vs = 0; c_fs = 0; c_col = 0;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        int          x;
        int          y;
        int          mode;
        logic [11:0] color;
        int          exp_color;
        int          exp_red;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fsb1, fsb3;
        logic [15:0] snap1, snap3;

        // x, y, fill mode (0 empty / 1 wall / 2 codes 0..3), colour to count, its count, red count
        vecs[0] = '{5,  4,  0, 12'h000, 375, 9};
        vecs[1] = '{0,  0,  0, 12'h000, 379, 5};
        vecs[2] = '{15, 11, 1, 12'h888, 187, 5};
        vecs[3] = '{8,  6,  2, 12'hDB5, 47,  9};
        vecs[4] = '{15, 0,  2, 12'h04F, 45,  5};

        reset_n = 1'b0;
        mx = '0;
        my = '0;
        cur_color = 12'h000;
        fill_mem(0);

        // Address ramp: 0..15 on the active part of line 0, hold 15, then 16.
        start_scene(5, 4, 0, 12'h000);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 15) check("addr_line0_end", int'(addr1), 15);
            if (k == 16) check("addr_hold_start", int'(addr1), 15);
            if (k == 23) check("addr_hold_end", int'(addr1), 15);
            if (k == 24) check("addr_line1_start", int'(addr1), 16);
        end

        // One frame per table row.
        for (int i = 0; i < 5; i++) begin
            start_scene(vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].color);
            repeat (FRAME + P3 + 4) @(negedge clk);
            #1;
            check($sformatf("v%0d red_pixels", i), c_red, vecs[i].exp_red);
            check($sformatf("v%0d colour_count", i), c_col, vecs[i].exp_color);
            check($sformatf("v%0d active_clocks", i), c_act, COLS*ROWS);
            check($sformatf("v%0d hsync_low", i), c_hs, HSY*VT);
            check($sformatf("v%0d vsync_low", i), c_vs, VSY*HT);
            check($sformatf("v%0d frame_starts", i), c_fs, 1);
            check_stream($sformatf("v%0d", i));
        end

        // Mid-frame reset at pixel (10,5), held for 3 clocks.
        start_scene(8, 6, 2, 12'h000);
        repeat (5*HT + 10) @(negedge clk);
        #1;
        snap1 = {fs1, vs1, hs1, act1, rgb1};
        check("pre_reset_active", int'(snap1), int'({4'b0111, 12'hF00}));
        reset_n = 1'b0;
        #1;
        snap1 = {fs1, vs1, hs1, act1, rgb1};
        snap3 = {fs3, vs3, hs3, act3, rgb3};
        check("async_reset_out_l1", int'(snap1), int'(RST_OUT));
        check("async_reset_out_l3", int'(snap3), int'(RST_OUT));
        check("async_reset_addr", int'(addr1), 0);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        fsb1 = '0;
        fsb3 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            fsb1[k-1] = fs1;
            fsb3[k-1] = fs3;
            if (k == 1) check("restart_addr", int'(addr1), 1);
        end
        check("restart_fs_l1", int'(fsb1), int'(6'b000010));
        check("restart_fs_l3", int'(fsb3), int'(6'b001000));
        repeat (FRAME) @(negedge clk);
        #1;
        check_stream("mid_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/framebuffer_scan_reader.md
Name: framebuffer_scan_reader

Overview:
- Read-side counterpart of the mouse pixel writer. Scans the cell RAM in raster order and produces VGA timing plus 12-bit RGB for the monitor.
- Generates read addresses, absorbs the RAM read latency and maps each cell code through a fixed palette.
- Overlays a crosshair cursor at the mouse position.
- Sits between the dual-port cell RAM (read port) and the VGA pins. clk_i is the pixel clock (25 MHz for 640x480@60).

Parameters:
- COLUMNS, 640, active pixels per line.
- ROWS, 480, active lines per frame.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, horizontal sync width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- RAM_LATENCY, 1, clocks from address to valid read data; legal range 1..3.
- CELL_WIDTH, 2, bits per RAM cell.
- CURSOR_COLOR, 12'hF00, RGB of the cursor.

Ports:
- clk_i  in  1  pixel clock.
- reset_ni  in  1  asynchronous, active-low reset.
- mouse_x_position_i  in  $clog2(COLUMNS)  cursor column.
- mouse_y_position_i  in  $clog2(ROWS)  cursor row.
- ram_rd_address_o  out  $clog2(COLUMNS*ROWS)  cell read address, row-major.
- ram_rd_data_i  in  CELL_WIDTH  cell code, valid RAM_LATENCY clocks after its address.
- rgb_o  out  12  {R[3:0],G[3:0],B[3:0]}.
- hsync_o  out  1  active-low horizontal sync.
- vsync_o  out  1  active-low vertical sync.
- video_active_o  out  1  high while rgb_o carries a visible pixel.
- frame_start_o  out  1  one-clock pulse, aligned with output of pixel (0,0).

Behaviour:
- Reset (reset_ni low, asynchronous):
  - h_count=0, v_count=0, address counter=0.
  - All pipeline stages cleared.
  - Outputs: rgb_o=0, hsync_o=1, vsync_o=1, video_active_o=0, frame_start_o=0, ram_rd_address_o=0.
  - The first clock after release is pixel (0,0) of a fresh frame.
- Horizontal counter:
  - h_count runs 0..H_TOTAL-1, where H_TOTAL = COLUMNS+H_FP+H_SYNC+H_BP = 800.
  - Active region: h < COLUMNS.
  - Sync low for COLUMNS+H_FP <= h < COLUMNS+H_FP+H_SYNC (656..751).
- Vertical counter:
  - v_count increments when h_count wraps; range 0..V_TOTAL-1, V_TOTAL = 525.
  - Active region: v < ROWS.
  - Sync low for lines 490..491.
  - Both counters wrap to 0 simultaneously at (799,524).
- Read addressing:
  - While the counters point at an active pixel (h,v), ram_rd_address_o = v*COLUMNS+h.
  - Implemented as an incrementing counter, not a multiplier.
  - The counter increments after each active pixel and holds through blanking.
  - It is forced to 0 when the counters wrap to (0,0).
  - It never exceeds COLUMNS*ROWS-1.
- Output pipeline:
  - Depth P = RAM_LATENCY+1 clocks.
  - hsync, vsync, active, frame_start and the cursor-hit flag are each delayed P clocks from the counter state.
  - Read data is sampled RAM_LATENCY clocks after its address, then registered once. This aligns it with the delayed active flag.
  - All outputs are registered; no combinational path from any input to any output.
- Palette (registered):
  - 0 -> 12'h000 (empty)
  - 1 -> 12'hDB5 (sand)
  - 2 -> 12'h888 (wall)
  - 3 -> 12'h04F (water)
  - If CELL_WIDTH > 2, codes >= 4 map to 12'hF0F.
- Cursor:
  - Hit when (h==mx and |v-my|<=2) or (v==my and |h-mx|<=2).
  - Differences computed at width+1 bits so there is no wrap: mouse at (0,0) draws only the in-frame arms, and nothing appears at column 639 or row 479.
  - Mouse inputs are sampled each clock without synchronisation (same clock domain); changes mid-frame take effect at the next pixel.
- Priority: blanking (rgb_o=0) > cursor (CURSOR_COLOR) > palette.
- Reset mid-frame: takes effect immediately. Pipeline contents are discarded, and after release the scan restarts at (0,0) with address 0.

Test Plan:
- Reset and release with RAM model latency 1 -> ram_rd_address_o steps 0,1,2,...,639 over the first 640 clocks, then holds 639 for 160 clocks; line 1 begins at address 640.
- Free-run one frame -> hsync_o low exactly 96 clocks per line, starting 656+P clocks after line start; vsync_o low lines 490..491; video_active_o high 307200 clocks per frame; frame_start_o pulses once per 420000 clocks.
- RAM preloaded with codes 0,1,2,3 repeating -> rgb_o sequence 000, DB5, 888, 04F starting P clocks after address 0; RAM_LATENCY=2 and 3 give identical pixel alignment relative to video_active_o.
- Mouse at (100,50) over all-empty RAM -> exactly 9 pixels equal F00: row 50 columns 98..102 and column 100 rows 48..52; mouse at (0,0) -> 5 red pixels, none at column 639/row 479.
- Wall cells everywhere -> rgb_o=0 whenever video_active_o=0 (porches and sync), 888 otherwise.
- Assert reset_ni low at (320,200) for 3 clocks -> all outputs at reset values within the same clock; after release the address restarts at 0 and frame_start_o pulses P clocks later.
